// File: rtl/video_sched_pkg.sv
// Shared types and constants for the frame-synchronous video write scheduler.
// The status word layout lives here so the RTL and any software view agree on it.
package video_sched_pkg;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int ENTRY_W        = 68;

  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_LEVEL_W   = 8;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FC_LSB    = 16;

  typedef enum logic {
    WAIT  = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vmem_entry_t;

  function automatic logic [31:0] pack_status(input logic [15:0] fc,
                                              input logic        empty,
                                              input logic [7:0]  level);
    logic [31:0] s;
    s = '0;
    s[STAT_FC_LSB +: 16]                = fc;
    s[STAT_EMPTY_BIT]                   = empty;
    s[STAT_LEVEL_LSB +: STAT_LEVEL_W]   = level;
    return s;
  endfunction

endpackage

// File: rtl/video_write_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout shows the head entry combinationally.
// Push on full and pop on empty are ignored so callers cannot corrupt the pointers.
module video_write_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 68,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Equal indices with differing wrap bits means the writer has lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = LVL_W'(wr_ptr_q - rd_ptr_q);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/video_write_scheduler.sv
// Queues CPU video writes and releases them to the peripheral only during vertical
// blanking (or when bypassed), so display state never changes mid-frame.
module video_write_scheduler
  import video_sched_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        vblank,
  input  logic        bypass,
  output logic        vmem_valid,
  output logic [3:0]  vmem_wstrb,
  output logic [31:0] vmem_addr,
  output logic [31:0] vmem_wdata,
  output logic [15:0] frame_count
);

  sched_state_e state_q, state_d;

  logic             vblank_q;
  logic             vblank_prev_q;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             iomem_ready_q;
  logic [31:0]      iomem_rdata_q, iomem_rdata_d;
  logic             vmem_valid_q;
  vmem_entry_t      vmem_entry_q, vmem_entry_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  vmem_entry_t      fifo_din;
  vmem_entry_t      fifo_dout;

  logic             drain_en;
  logic             wr_req;
  logic             rd_req;
  logic             push;
  logic             pop;

  assign drain_en = vblank_q || bypass;
  assign wr_req   = iomem_valid && (iomem_wstrb != 4'b0) && !iomem_ready_q;
  assign rd_req   = iomem_valid && (iomem_wstrb == 4'b0) && !iomem_ready_q;
  assign push     = wr_req && !fifo_full;
  assign fifo_din = {iomem_wstrb, iomem_addr, iomem_wdata};

  video_write_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:  if (drain_en && !fifo_empty)  state_d = DRAIN;
      DRAIN: if (fifo_empty || !drain_en)  state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // Pop in the same cycle the FSM commits to DRAIN so blanking start costs only the vblank register.
  always_comb begin
    pop           = (state_d == DRAIN);
    vmem_entry_d  = pop ? fifo_dout : '0;
    iomem_rdata_d = rd_req ? pack_status(frame_count_q, fifo_empty, 8'(fifo_level)) : 32'h0;
    frame_count_d = (vblank_q && !vblank_prev_q) ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q      <= 1'b0;
      vblank_prev_q <= 1'b0;
      frame_count_q <= '0;
      iomem_ready_q <= 1'b0;
      iomem_rdata_q <= '0;
      vmem_valid_q  <= 1'b0;
      vmem_entry_q  <= '0;
    end else begin
      vblank_q      <= vblank;
      vblank_prev_q <= vblank_q;
      frame_count_q <= frame_count_d;
      iomem_ready_q <= push || rd_req;
      iomem_rdata_q <= iomem_rdata_d;
      vmem_valid_q  <= pop;
      vmem_entry_q  <= vmem_entry_d;
    end
  end

  assign iomem_ready = iomem_ready_q;
  assign iomem_rdata = iomem_rdata_q;
  assign vmem_valid  = vmem_valid_q;
  assign vmem_wstrb  = vmem_entry_q.wstrb;
  assign vmem_addr   = vmem_entry_q.addr;
  assign vmem_wdata  = vmem_entry_q.wdata;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_write_scheduler.sv
// Bench for video_write_scheduler: queue-level reference model checked every cycle,
// plus hand-computed expectations for the blanking, stall, bypass and reset scenarios.
module tb_video_write_scheduler;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        vblank;
  logic        bypass;
  logic        vmem_valid;
  logic [3:0]  vmem_wstrb;
  logic [31:0] vmem_addr;
  logic [31:0] vmem_wdata;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  video_write_scheduler #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .vblank      (vblank),
    .bypass      (bypass),
    .vmem_valid  (vmem_valid),
    .vmem_wstrb  (vmem_wstrb),
    .vmem_addr   (vmem_addr),
    .vmem_wdata  (vmem_wdata),
    .frame_count (frame_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a plain queue plus the blanking window (vblank seen last cycle, or bypass).
  logic [67:0] mq[$];
  logic        mReady = 1'b0;
  logic [31:0] mRdata = '0;
  logic        mVvalid = 1'b0;
  logic [67:0] mVent = '0;
  logic [15:0] mFc = '0;
  logic        mVb1 = 1'b0;
  logic        mVb2 = 1'b0;
  bit          modelLive = 1'b0;

  always @(posedge clk) begin : model
    logic popping, pushing, reading;
    if (reset) begin
      mq.delete();
      mReady = 1'b0; mRdata = '0; mVvalid = 1'b0; mVent = '0;
      mFc = '0; mVb1 = 1'b0; mVb2 = 1'b0;
    end else begin
      popping = (mVb1 || bypass) && (mq.size() > 0);
      reading = iomem_valid && (iomem_wstrb == 4'b0) && !mReady;
      pushing = iomem_valid && (iomem_wstrb != 4'b0) && !mReady && (mq.size() < DEPTH);
      mRdata  = reading ? {mFc, 7'b0, (mq.size() == 0), 8'(mq.size())} : 32'h0;
      mReady  = pushing || reading;
      if (popping) begin
        mVvalid = 1'b1;
        mVent   = mq.pop_front();
      end else begin
        mVvalid = 1'b0;
        mVent   = '0;
      end
      if (pushing) mq.push_back({iomem_wstrb, iomem_addr, iomem_wdata});
      if (mVb1 && !mVb2) mFc = mFc + 16'd1;
      mVb2 = mVb1;
      mVb1 = vblank;
    end
    modelLive = 1'b1;
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("iomem_ready", {67'b0, iomem_ready}, {67'b0, mReady});
      checkOutput("iomem_rdata", {36'b0, iomem_rdata}, {36'b0, mRdata});
      checkOutput("vmem_valid",  {67'b0, vmem_valid},  {67'b0, mVvalid});
      checkOutput("vmem_entry",  {vmem_wstrb, vmem_addr, vmem_wdata}, mVent);
      checkOutput("frame_count", {52'b0, frame_count}, {52'b0, mFc});
    end
  end

  // Record every peripheral write pulse for the scenario checks.
  int          pCyc[$];
  logic [31:0] pAddr[$];
  logic [31:0] pData[$];

  always @(negedge clk) begin
    if (modelLive && !reset && vmem_valid === 1'b1) begin
      pCyc.push_back(cyc);
      pAddr.push_back(vmem_addr);
      pData.push_back(vmem_wdata);
    end
  end

  task automatic clearPulses();
    pCyc.delete(); pAddr.delete(); pData.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic startRequest(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output int reqCyc);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_wstrb = s;
    iomem_addr  = a;
    iomem_wdata = d;
    reqCyc      = cyc;
  endtask

  task automatic waitReady(input int budget, output logic [31:0] rd);
    bit seen = 1'b0;
    rd = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (iomem_ready === 1'b1) begin
        seen = 1'b1;
        rd   = iomem_rdata;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: got no iomem_ready, expected one within %0d cycles", budget);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rd);
    int rc;
    startRequest(a, d, s, rc);
    waitReady(8, rd);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [31:0] rd;
    int n;
    int rc;

    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0;
    iomem_wdata = '0; vblank = 1'b0; bypass = 1'b0;
    idle(3);
    reset = 1'b0;
    checkOutput("reset_ready",  {67'b0, iomem_ready}, 68'd0);
    checkOutput("reset_vvalid", {67'b0, vmem_valid},  68'd0);
    checkOutput("reset_fc",     {52'b0, frame_count}, 68'd0);

    // Writes during active video stay queued.
    clearPulses();
    for (int i = 0; i < 3; i++) applyStimulus(32'h0200_0000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF, rd);
    idle(2);
    checkOutput("active_no_vmem", 68'(pCyc.size()), 68'd0);
    applyStimulus(32'h0, 32'h0, 4'h0, rd);
    checkOutput("status_level3", {36'b0, rd}, {36'b0, 32'h0000_0003});

    // Blanking drain: first pulse two cycles after vblank rises, in FIFO order.
    clearPulses();
    @(negedge clk); vblank = 1'b1; n = cyc;
    idle(6);
    checkOutput("drain_count", 68'(pCyc.size()), 68'd3);
    if (pCyc.size() == 3) begin
      checkOutput("drain_first_cyc", 68'(pCyc[0]), 68'(n + 2));
      checkOutput("drain_last_cyc",  68'(pCyc[2]), 68'(n + 4));
      checkOutput("drain_addr0", {36'b0, pAddr[0]}, {36'b0, 32'h0200_0000});
      checkOutput("drain_addr2", {36'b0, pAddr[2]}, {36'b0, 32'h0200_0008});
      checkOutput("drain_data1", {36'b0, pData[1]}, {36'b0, 32'h1111_0001});
    end
    checkOutput("fc_after_drain", {52'b0, frame_count}, 68'd1);
    applyStimulus(32'h0, 32'h0, 4'h0, rd);
    checkOutput("status_empty", {36'b0, rd}, {36'b0, 32'h0001_0100});
    vblank = 1'b0;
    idle(2);

    // Full queue stalls the 17th write until blanking frees a slot.
    clearPulses();
    for (int i = 0; i < DEPTH; i++) applyStimulus(32'h0300_0000 + 32'(4 * i), 32'(i), 4'h3, rd);
    startRequest(32'h0300_0040, 32'h0000_0016, 4'h3, rc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_ready_low", {67'b0, iomem_ready}, 68'd0);
    end
    vblank = 1'b1;
    waitReady(20, rd);
    idle(22);
    checkOutput("stall_drain_count", 68'(pCyc.size()), 68'd17);
    if (pCyc.size() == 17) begin
      checkOutput("stall_addr0",  {36'b0, pAddr[0]},  {36'b0, 32'h0300_0000});
      checkOutput("stall_addr16", {36'b0, pAddr[16]}, {36'b0, 32'h0300_0040});
    end
    vblank = 1'b0;
    idle(3);
    checkOutput("fc_after_stall", {52'b0, frame_count}, 68'd2);

    // Blanking ends mid-drain: four pulses now, the remaining six next interval.
    clearPulses();
    for (int i = 0; i < 10; i++) applyStimulus(32'h0400_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, rd);
    @(negedge clk); vblank = 1'b1; n = cyc;
    idle(4);
    vblank = 1'b0;
    idle(6);
    checkOutput("partial_count", 68'(pCyc.size()), 68'd4);
    if (pCyc.size() == 4) begin
      checkOutput("partial_last_cyc", 68'(pCyc[3]), 68'(n + 5));
      checkOutput("partial_addr3", {36'b0, pAddr[3]}, {36'b0, 32'h0400_000C});
    end
    idle(4);
    vblank = 1'b1;
    idle(12);
    vblank = 1'b0;
    idle(3);
    checkOutput("resume_count", 68'(pCyc.size()), 68'd10);
    if (pCyc.size() == 10) begin
      checkOutput("resume_addr4", {36'b0, pAddr[4]}, {36'b0, 32'h0400_0010});
      checkOutput("resume_addr9", {36'b0, pAddr[9]}, {36'b0, 32'h0400_0024});
    end
    checkOutput("fc_after_partial", {52'b0, frame_count}, 68'd4);

    // Bypass drains outside blanking.
    clearPulses();
    bypass = 1'b1;
    startRequest(32'h0200_0010, 32'hDEAD_BEEF, 4'hF, rc);
    waitReady(8, rd);
    idle(3);
    checkOutput("bypass_count", 68'(pCyc.size()), 68'd1);
    if (pCyc.size() == 1) begin
      checkOutput("bypass_cyc",  68'(pCyc[0]), 68'(rc + 2));
      checkOutput("bypass_addr", {36'b0, pAddr[0]}, {36'b0, 32'h0200_0010});
      checkOutput("bypass_data", {36'b0, pData[0]}, {36'b0, 32'hDEAD_BEEF});
    end
    bypass = 1'b0;
    idle(2);

    // Reset during a drain discards whatever is still queued.
    clearPulses();
    for (int i = 0; i < 5; i++) applyStimulus(32'h0500_0000 + 32'(4 * i), 32'(i), 4'hF, rd);
    vblank = 1'b1;
    begin
      int budget = 10;
      while (pCyc.size() == 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (pCyc.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL reset_drain_start: got no vmem_valid, expected a drain within 10 cycles");
      end
    end
    reset  = 1'b1;
    vblank = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_vvalid", {67'b0, vmem_valid},  68'd0);
    checkOutput("reset_mid_fc",     {52'b0, frame_count}, 68'd0);
    reset = 1'b0;
    applyStimulus(32'h0, 32'h0, 4'h0, rd);
    checkOutput("reset_mid_status", {36'b0, rd}, {36'b0, 32'h0000_0100});
    clearPulses();
    vblank = 1'b1;
    idle(6);
    vblank = 1'b0;
    idle(2);
    checkOutput("reset_nothing_left", 68'(pCyc.size()), 68'd0);
    checkOutput("reset_then_fc", {52'b0, frame_count}, 68'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
